// File: rtl/regfile_2w3r_sb.sv
// regfile_2w3r_sb: integer register file with three combinational read ports,
// two write ports (0 = ALU writeback, 1 = load writeback), optional write-to-read
// bypass, optional hardwired zero register at the top index, and a per-register
// busy scoreboard for outstanding loads.
//
// Ports
//   Clk, ResetL          : rising-edge clock, asynchronous active-low reset
//   RA, RB, RC           : read addresses (A/B operands, C store data)
//   BusA, BusB, BusC     : read data
//   RW0, BusW0, RegWr0   : write port 0 (ALU) address / data / enable
//   RW1, BusW1, RegWr1   : write port 1 (load) address / data / enable; also clears busy
//   SetBusy, RBusy       : mark register RBusy as having a load in flight
//   BusyA, BusyB, BusyC  : the register on the matching read port is pending
//   PendingCount         : number of busy bits currently set (registered)

module regfile_2w3r_sb #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic [DATA_W-1:0] BusC,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [DATA_W-1:0] BusW0,
  input  logic              RegWr0,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [DATA_W-1:0] BusW1,
  input  logic              RegWr1,
  input  logic              SetBusy,
  input  logic [ADDR_W-1:0] RBusy,
  output logic              BusyA,
  output logic              BusyB,
  output logic              BusyC,
  output logic [ADDR_W:0]   PendingCount
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroIdx = '1;

  // True when the address names the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ZeroIdx);
  endfunction

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic we0, we1;

  assign we0 = RegWr0 && !is_zero(RW0);
  assign we1 = RegWr1 && !is_zero(RW1);

  // Storage. Port 0 is assigned last so it wins on a same-address collision.
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (we1) begin
        regs_q[RW1] <= BusW1;
      end
      if (we0) begin
        regs_q[RW0] <= BusW0;
      end
    end
  end

  // Scoreboard next state: clear on load return first, then set, so a new load
  // issued to the register that is returning keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (RegWr1) begin
      busy_d[RW1] = 1'b0;
    end
    if (SetBusy && !is_zero(RBusy)) begin
      busy_d[RBusy] = 1'b1;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < Depth; i++) begin
      count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign PendingCount = count_q;

  // Read ports.
  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];
  logic              rd_busy [3];

  always_comb begin
    rd_addr[0] = RA;
    rd_addr[1] = RB;
    rd_addr[2] = RC;
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (BYPASS != 0) begin
        if (RegWr1 && (RW1 == rd_addr[p])) begin
          rd_data[p] = BusW1;
          rd_busy[p] = 1'b0;
        end
        // ALU result is the younger instruction, so it overrides the load.
        if (RegWr0 && (RW0 == rd_addr[p])) begin
          rd_data[p] = BusW0;
        end
      end
      if (is_zero(rd_addr[p])) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign BusA  = rd_data[0];
  assign BusB  = rd_data[1];
  assign BusC  = rd_data[2];
  assign BusyA = rd_busy[0];
  assign BusyB = rd_busy[1];
  assign BusyC = rd_busy[2];

endmodule

// File: tb/tb_regfile_2w3r_sb.sv
// Bench for regfile_2w3r_sb: two instances share all inputs, instance 0 with
// ZERO_REG=1/BYPASS=1 and instance 1 with ZERO_REG=0/BYPASS=0. Directed sequences
// followed by random traffic, all compared against an array-based reference model.

module tb_regfile_2w3r_sb;

  logic        Clk = 1'b0;
  logic        ResetL = 1'b0;
  logic [4:0]  RA = '0, RB = '0, RC = '0, RW0 = '0, RW1 = '0, RBusy = '0;
  logic [63:0] BusW0 = '0, BusW1 = '0;
  logic        RegWr0 = 1'b0, RegWr1 = 1'b0, SetBusy = 1'b0;

  logic [63:0] bus_a [2];
  logic [63:0] bus_b [2];
  logic [63:0] bus_c [2];
  logic        busy_a [2];
  logic        busy_b [2];
  logic        busy_c [2];
  logic [5:0]  pend [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one copy per instance.
  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];

  always #5 Clk = ~Clk;

  regfile_2w3r_sb #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RC(RC),
    .BusA(bus_a[0]), .BusB(bus_b[0]), .BusC(bus_c[0]),
    .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
    .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1),
    .SetBusy(SetBusy), .RBusy(RBusy),
    .BusyA(busy_a[0]), .BusyB(busy_b[0]), .BusyC(busy_c[0]),
    .PendingCount(pend[0])
  );

  regfile_2w3r_sb #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RC(RC),
    .BusA(bus_a[1]), .BusB(bus_b[1]), .BusC(bus_c[1]),
    .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
    .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1),
    .SetBusy(SetBusy), .RBusy(RBusy),
    .BusyA(busy_a[1]), .BusyB(busy_b[1]), .BusyC(busy_c[1]),
    .PendingCount(pend[1])
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_read(input int inst, input logic [4:0] a);
    bit zr  = (inst == 0);
    bit byp = (inst == 0);
    if (zr && a == 5'd31) return 64'd0;
    if (byp && RegWr0 && RW0 == a) return BusW0;
    if (byp && RegWr1 && RW1 == a) return BusW1;
    return m_mem[inst][a];
  endfunction

  function automatic logic exp_busy(input int inst, input logic [4:0] a);
    bit byp = (inst == 0);
    if (byp && RegWr1 && RW1 == a) return 1'b0;
    return m_busy[inst][a];
  endfunction

  function automatic int exp_count(input int inst);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[inst][i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
    end
  endtask

  // Clock-edge update of the model from the current inputs.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit zr = (k == 0);
      if (RegWr1 && !(zr && RW1 == 5'd31)) m_mem[k][RW1] = BusW1;
      if (RegWr0 && !(zr && RW0 == 5'd31)) m_mem[k][RW0] = BusW0;
      if (RegWr1) m_busy[k][RW1] = 1'b0;
      if (SetBusy && !(zr && RBusy == 5'd31)) m_busy[k][RBusy] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("i%0d BusA[%0d]", k, RA), bus_a[k], exp_read(k, RA));
      check_val($sformatf("i%0d BusB[%0d]", k, RB), bus_b[k], exp_read(k, RB));
      check_val($sformatf("i%0d BusC[%0d]", k, RC), bus_c[k], exp_read(k, RC));
      check_val($sformatf("i%0d BusyA[%0d]", k, RA), 64'(busy_a[k]), 64'(exp_busy(k, RA)));
      check_val($sformatf("i%0d BusyB[%0d]", k, RB), 64'(busy_b[k]), 64'(exp_busy(k, RB)));
      check_val($sformatf("i%0d BusyC[%0d]", k, RC), 64'(busy_c[k]), 64'(exp_busy(k, RC)));
      check_val($sformatf("i%0d PendingCount", k), 64'(pend[k]), 64'(exp_count(k)));
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic run_cycle();
    #2;
    check_all();
    @(posedge Clk);
    model_update();
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    RegWr0 = 1'b0;
    RegWr1 = 1'b0;
    SetBusy = 1'b0;
  endtask

  // Reset asserted between edges; a write and SetBusy are held across the
  // following rising edge and must be discarded.
  task automatic do_reset();
    idle_inputs();
    #2;
    ResetL = 1'b0;
    model_reset();
    #1;
    check_all();
    RegWr0 = 1'b1; RW0 = 5'd2; BusW0 = 64'hDEAD;
    SetBusy = 1'b1; RBusy = 5'd2;
    @(posedge Clk);
    @(negedge Clk);
    idle_inputs();
    ResetL = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge Clk);
    ResetL = 1'b1;

    // Write X1 = 0x55, then reset and see it gone immediately.
    RegWr0 = 1'b1; RW0 = 5'd1; BusW0 = 64'h55; RA = 5'd1;
    run_cycle();
    idle_inputs();
    run_cycle();
    do_reset();
    RA = 5'd1; RB = 5'd2;
    run_cycle();

    // Dual write to the same address: port 0 wins, bypassed and stored.
    RegWr0 = 1'b1; RegWr1 = 1'b1; RW0 = 5'd3; RW1 = 5'd3;
    BusW0 = 64'hAAAA; BusW1 = 64'hBBBB; RA = 5'd3;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Load bypass to read port B.
    RegWr1 = 1'b1; RW1 = 5'd7; BusW1 = 64'h1234; RB = 5'd7;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Zero register write and SetBusy.
    RegWr0 = 1'b1; RW0 = 5'd31; BusW0 = 64'hFFFF; SetBusy = 1'b1; RBusy = 5'd31; RC = 5'd31;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Scoreboard on reg 5: set, return, then set and return together.
    RA = 5'd5;
    SetBusy = 1'b1; RBusy = 5'd5;
    run_cycle();
    idle_inputs();
    run_cycle();
    RegWr1 = 1'b1; RW1 = 5'd5; BusW1 = 64'h5555;
    run_cycle();
    idle_inputs();
    run_cycle();
    SetBusy = 1'b1; RBusy = 5'd5;
    run_cycle();
    RegWr1 = 1'b1; RW1 = 5'd5;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Saturation: every writable register busy, then repeats and the top index.
    for (int i = 0; i < 31; i++) begin
      SetBusy = 1'b1; RBusy = 5'(i); RA = 5'(i);
      run_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      SetBusy = 1'b1; RBusy = 5'd0;
      run_cycle();
    end
    SetBusy = 1'b1; RBusy = 5'd31;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      RA = ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom_range(31));
      RB = ($urandom_range(3) == 0) ? RW0 : 5'($urandom_range(31));
      RC = ($urandom_range(3) == 0) ? RW1 : 5'($urandom_range(31));
      RW0 = ($urandom_range(5) == 0) ? 5'd31 : 5'($urandom_range(7));
      RW1 = ($urandom_range(5) == 0) ? 5'd31 : 5'($urandom_range(7));
      RBusy = ($urandom_range(5) == 0) ? 5'd31 : 5'($urandom_range(7));
      BusW0 = {$urandom, $urandom};
      BusW1 = {$urandom, $urandom};
      RegWr0 = 1'($urandom_range(1));
      RegWr1 = 1'($urandom_range(1));
      SetBusy = 1'($urandom_range(1));
      if ($urandom_range(63) == 0) do_reset();
      else run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
